// File: rtl/ep_streamer_pkg.sv
// Shared types and constants for the endpoint IN packet streamer.
// Optional feature macro: EP_STREAMER_RETRY_CNT_EN (adds the retryCount output).
package ep_streamer_pkg;

  // Width of the optional retransmission counter.
  localparam int RETRY_CNT_WID = 8;

  // Streamer FSM states.
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    EOP,
    WAIT_RESULT,
    COMMIT,
    ROLLBACK
  } ep_streamer_state_t;

  // States in which an abort from the protocol engine forces a rollback.
  function automatic logic is_abortable(input ep_streamer_state_t st);
    return (st == FETCH) || (st == SEND) || (st == EOP) || (st == WAIT_RESULT);
  endfunction

endpackage

// File: rtl/ep_tx_hold_reg.sv
// One-entry data register holding the byte currently offered to the serializer.
// Load captures din, clear zeroes it, otherwise the value is held.
module ep_tx_hold_reg #(
  parameter int WID = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           clear,
  input  logic [WID-1:0] din,
  output logic [WID-1:0] dout
);

  // Clear has priority over load so a fresh packet never shows a stale byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (clear) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ep_in_packet_streamer.sv
// Drains one USB IN packet from the endpoint FIFO pop side, streams it byte by
// byte to the transmit serializer followed by an EOP beat, then commits or
// rolls back the pop transaction depending on the host handshake.
// Optional feature macro: EP_STREAMER_RETRY_CNT_EN (adds the retryCount output).
module ep_in_packet_streamer
  import ep_streamer_pkg::*;
#(
  parameter int EP_DATA_WID     = 8,
  parameter int MAX_PACKET_SIZE = 64,
  parameter int CNT_WID         = $clog2(MAX_PACKET_SIZE + 1)
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     txStart,
  input  logic                     txAbort,
  input  logic                     resultValid,
  input  logic                     resultAck,
  input  logic                     txReady,
  output logic                     txValid,
  output logic [EP_DATA_WID-1:0]   txData,
  output logic                     txEop,
  output logic                     busy,
  output logic [CNT_WID-1:0]       byteCount,
  output logic                     popData,
  output logic                     popTransDone,
  output logic                     popTransSuccess,
`ifdef EP_STREAMER_RETRY_CNT_EN
  output logic [RETRY_CNT_WID-1:0] retryCount,
`endif
  input  logic                     dataAvailable,
  input  logic [EP_DATA_WID-1:0]   dataOut
);

  localparam logic [CNT_WID-1:0] MAX_CNT = CNT_WID'(MAX_PACKET_SIZE);

  ep_streamer_state_t state_q;
  ep_streamer_state_t state_d;

  logic                   start_pkt;
  logic [EP_DATA_WID-1:0] hold_data;

  assign start_pkt = (state_q == IDLE) && txStart;
  assign busy      = (state_q != IDLE);

  // Holding register: captures the FIFO head on each pop, cleared on a new packet.
  ep_tx_hold_reg #(
    .WID (EP_DATA_WID)
  ) u_hold (
    .clk   (CLK),
    .rst_n (RSTn),
    .load  (popData),
    .clear (start_pkt),
    .din   (dataOut),
    .dout  (hold_data)
  );

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; abort overrides every other transition.
  always_comb begin
    state_d         = state_q;
    txValid         = 1'b0;
    txData          = '0;
    txEop           = 1'b0;
    popData         = 1'b0;
    popTransDone    = 1'b0;
    popTransSuccess = 1'b0;

    case (state_q)
      IDLE: begin
        if (txStart) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (dataAvailable && (byteCount < MAX_CNT)) begin
          popData = 1'b1;
          state_d = SEND;
        end else begin
          state_d = EOP;
        end
      end
      SEND: begin
        txValid = 1'b1;
        txData  = hold_data;
        if (txReady) begin
          state_d = FETCH;
        end
      end
      EOP: begin
        txValid = 1'b1;
        txEop   = 1'b1;
        if (txReady) begin
          state_d = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        if (resultValid) begin
          state_d = resultAck ? COMMIT : ROLLBACK;
        end
      end
      COMMIT: begin
        popTransDone    = 1'b1;
        popTransSuccess = 1'b1;
        state_d         = IDLE;
      end
      ROLLBACK: begin
        popTransDone = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (txAbort && is_abortable(state_q)) begin
      popData = 1'b0;
      state_d = ROLLBACK;
    end
  end

  // Byte counter: cleared on packet start, bumped per pop; the FETCH guard stops it at the max.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      byteCount <= '0;
    end else if (start_pkt) begin
      byteCount <= '0;
    end else if (popData) begin
      byteCount <= byteCount + 1'b1;
    end
  end

`ifdef EP_STREAMER_RETRY_CNT_EN
  // Retry counter: counts rollbacks (saturating), cleared by a successful commit.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      retryCount <= '0;
    end else if (state_q == COMMIT) begin
      retryCount <= '0;
    end else if ((state_q == ROLLBACK) && (retryCount != '1)) begin
      retryCount <= retryCount + 1'b1;
    end
  end
`endif

endmodule
